vector_square: RTL and testbench

//  Two-lane unsigned squarer for the vector machine datapath. Each cycle it can

---
 rtl/vector_square.sv | 63 ++++++
 tb/tb_vector_square.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_square.sv
// Two-lane unsigned squarer: fixed 2-cycle latency, one result pair per clock.
// Each lane returns the low WIDTH bits of its square plus an overflow flag.
module vector_square #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    output logic             out_valid,
    output logic [WIDTH-1:0] square_1,
    output logic [WIDTH-1:0] square_2,
    output logic             ovf_1,
    output logic             ovf_2
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data_1;
    logic [WIDTH-1:0] s1_data_2;
    logic [2*WIDTH-1:0] product_1;
    logic [2*WIDTH-1:0] product_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data_1 <= '0;
            s1_data_2 <= '0;
        end else begin
            s1_valid <= in_valid;
            // Operand registers only load on valid input, saving toggles on bubbles.
            if (in_valid) begin
                s1_data_1 <= data_1;
                s1_data_2 <= data_2;
            end
        end
    end

    always_comb begin
        product_1 = {{WIDTH{1'b0}}, s1_data_1} * {{WIDTH{1'b0}}, s1_data_1};
        product_2 = {{WIDTH{1'b0}}, s1_data_2} * {{WIDTH{1'b0}}, s1_data_2};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            square_1  <= '0;
            square_2  <= '0;
            ovf_1     <= 1'b0;
            ovf_2     <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            // Results hold their last value through bubbles.
            if (s1_valid) begin
                square_1 <= product_1[WIDTH-1:0];
                square_2 <= product_2[WIDTH-1:0];
                ovf_1    <= |product_1[2*WIDTH-1:WIDTH];
                ovf_2    <= |product_2[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_vector_square.sv
// Directed and random checks of vector_square against hand-computed squares.
module tb_vector_square;

    localparam int unsigned W = 24;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] data_1;
    logic [W-1:0] data_2;
    logic         out_valid;
    logic [W-1:0] square_1;
    logic [W-1:0] square_2;
    logic         ovf_1;
    logic         ovf_2;

    int tests_run;
    int tests_failed;

    vector_square #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_1    (data_1),
        .data_2    (data_2),
        .out_valid (out_valid),
        .square_1  (square_1),
        .square_2  (square_2),
        .ovf_1     (ovf_1),
        .ovf_2     (ovf_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one input cycle, then advance past the next rising edge.
    // Afterwards the outputs reflect the input driven on the previous call.
    task automatic cycle(input logic v, input logic [W-1:0] d1, input logic [W-1:0] d2);
        in_valid = v;
        data_1   = d1;
        data_2   = d2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2*W+2:0] obs;
        // Outputs under initial reset
        obs = {out_valid, ovf_1, ovf_2, square_1, square_2};
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("FAIL reset_initial: got %h want 0", obs);
        end
        rst = 1'b0;
        cycle(1'b1, 24'd3, 24'd5);
        cycle(1'b1, 24'd7, 24'd9);
        cycle(1'b1, 24'd11, 24'd13);
        tests_run++;
        if (out_valid !== 1'b1 || square_1 !== 24'd49 || square_2 !== 24'd81) begin
            tests_failed++;
            $display("FAIL reset_preload: got v=%b %0d %0d want v=1 49 81", out_valid, square_1, square_2);
        end
        // Assert reset mid-cycle with data in both stages; no clock edge follows.
        #2;
        rst = 1'b1;
        #1;
        obs = {out_valid, ovf_1, ovf_2, square_1, square_2};
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: got %h want 0", obs);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 24'd0, 24'd0);
            obs = {out_valid, ovf_1, ovf_2, square_1, square_2};
            tests_run++;
            if (obs !== '0) begin
                tests_failed++;
                $display("FAIL reset_release_%0d: got %h want 0", i, obs);
            end
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] e1 [3] = '{24'd1, 24'd100, 24'd1600};
        logic [W-1:0] e2 [3] = '{24'd4, 24'd900, 24'd5929};
        cycle(1'b1, 24'd1, 24'd2);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: cycle(1'b1, 24'd10, 24'd30);
                1: cycle(1'b1, 24'd40, 24'd77);
                default: cycle(1'b0, 24'd0, 24'd0);
            endcase
            tests_run++;
            if (i < 3) begin
                if (out_valid !== 1'b1 || square_1 !== e1[i] || square_2 !== e2[i]
                    || ovf_1 !== 1'b0 || ovf_2 !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL basic_%0d: got v=%b %0d/%b %0d/%b want v=1 %0d/0 %0d/0",
                             i, out_valid, square_1, ovf_1, square_2, ovf_2, e1[i], e2[i]);
                end
            end else if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_drain: got out_valid=%b want 0", out_valid);
            end
        end
    endtask

    task automatic test_boundary();
        cycle(1'b1, 24'd4095, 24'd4096);
        cycle(1'b0, 24'd0, 24'd0);
        tests_run++;
        if (out_valid !== 1'b1 || square_1 !== 24'd16769025 || ovf_1 !== 1'b0
            || square_2 !== 24'd0 || ovf_2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL boundary: got v=%b %0d/%b %0d/%b want v=1 16769025/0 0/1",
                     out_valid, square_1, ovf_1, square_2, ovf_2);
        end
    endtask

    task automatic test_extremes();
        cycle(1'b1, 24'd0, 24'hFFFFFF);
        cycle(1'b0, 24'd0, 24'd0);
        tests_run++;
        if (out_valid !== 1'b1 || square_1 !== 24'd0 || ovf_1 !== 1'b0
            || square_2 !== 24'd1 || ovf_2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL extremes: got v=%b %0d/%b %0d/%b want v=1 0/0 1/1",
                     out_valid, square_1, ovf_1, square_2, ovf_2);
        end
    endtask

    task automatic test_back_to_back();
        // Inputs: (5,6) bubble (100,200) (5000,3) then drain.
        logic         ev [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] e1 [5] = '{24'd25, 24'd0, 24'd10000, 24'd25000000 - 24'd16777216, 24'd0};
        logic [W-1:0] e2 [5] = '{24'd36, 24'd0, 24'd40000, 24'd9, 24'd0};
        logic         o1 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        cycle(1'b1, 24'd5, 24'd6);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: cycle(1'b0, 24'd77, 24'd88);
                1: cycle(1'b1, 24'd100, 24'd200);
                2: cycle(1'b1, 24'd5000, 24'd3);
                default: cycle(1'b0, 24'd0, 24'd0);
            endcase
            tests_run++;
            if (out_valid !== ev[i]) begin
                tests_failed++;
                $display("FAIL b2b_valid_%0d: got %b want %b", i, out_valid, ev[i]);
            end else if (ev[i] && (square_1 !== e1[i] || square_2 !== e2[i]
                                   || ovf_1 !== o1[i] || ovf_2 !== 1'b0)) begin
                tests_failed++;
                $display("FAIL b2b_data_%0d: got %0d/%b %0d/%b want %0d/%b %0d/0",
                         i, square_1, ovf_1, square_2, ovf_2, e1[i], o1[i], e2[i]);
            end
        end
    endtask

    task automatic test_random();
        logic         pv;
        logic [W-1:0] p1, p2;
        logic         v;
        logic [W-1:0] d1, d2;
        logic [2*W-1:0] f1, f2;
        int errs;
        errs = 0;
        pv = 1'b0;
        p1 = '0;
        p2 = '0;
        for (int i = 0; i < 1000; i++) begin
            v  = 1'($urandom_range(0, 3) != 0);
            d1 = W'($urandom);
            d2 = W'($urandom);
            if (i % 50 == 7)  d1 = 24'hFFFFFF;
            if (i % 50 == 13) d2 = 24'd4095;
            cycle(v, d1, d2);
            f1 = 48'(p1) * 48'(p1);
            f2 = 48'(p2) * 48'(p2);
            tests_run++;
            if (out_valid !== pv) begin
                tests_failed++;
                if (errs++ < 10)
                    $display("FAIL rand_valid_%0d: got %b want %b", i, out_valid, pv);
            end else if (pv && (square_1 !== f1[W-1:0] || ovf_1 !== (f1[2*W-1:W] != 0)
                                || square_2 !== f2[W-1:0] || ovf_2 !== (f2[2*W-1:W] != 0))) begin
                tests_failed++;
                if (errs++ < 10)
                    $display("FAIL rand_data_%0d: got %h/%b %h/%b want %h/%b %h/%b", i,
                             square_1, ovf_1, square_2, ovf_2, f1[W-1:0], f1[2*W-1:W] != 0,
                             f2[W-1:0], f2[2*W-1:W] != 0);
            end
            pv = v;
            p1 = d1;
            p2 = d2;
        end
        cycle(1'b0, 24'd0, 24'd0);
        cycle(1'b0, 24'd0, 24'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        data_1   = '0;
        data_2   = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_boundary();
        test_extremes();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
